alu_op_sequencer: RTL and testbench

//  Command-driven sequencer for the 8-bit combinational ALU (add/sub/and/or/shift-of-sum).

---
 rtl/alu_op_sequencer_if.sv | 42 ++++
 rtl/alu_op_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Bundles the command, ALU-pin, response and status signals of alu_op_sequencer.
// Handshake: a transfer on cmd_* or res_* happens on a rising clk edge where both valid and ready are 1.
interface alu_op_sequencer_if #(
  parameter int AW = 2
);
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_shamt;
  logic        cmd_use_acc;
  logic        cmd_wb;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_ctrl;
  logic [2:0]  alu_movl;
  logic [2:0]  alu_movr;
  logic [7:0]  alu_result;
  logic [3:0]  alu_flags;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic [3:0]  res_flags;
  logic [7:0]  acc;
  logic        busy;
  logic [AW:0] fifo_count;

  modport slave (
    input  cmd_valid, cmd_op, cmd_shamt, cmd_use_acc, cmd_wb, cmd_a, cmd_b,
    input  alu_result, alu_flags, res_ready,
    output cmd_ready, alu_a, alu_b, alu_ctrl, alu_movl, alu_movr,
    output res_valid, res_data, res_flags, acc, busy, fifo_count
  );

  modport master (
    output cmd_valid, cmd_op, cmd_shamt, cmd_use_acc, cmd_wb, cmd_a, cmd_b,
    output alu_result, alu_flags, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_ctrl, alu_movl, alu_movr,
    input  res_valid, res_data, res_flags, acc, busy, fifo_count
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Command FIFO plus IDLE/ISSUE/CAPTURE/RESP sequencer driving an external 8-bit combinational ALU,
// with an accumulator usable as operand A for chained operations.
module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] shamt;
    logic       use_acc;
    logic       wb;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  cmd_t          mem_q [DEPTH];
  cmd_t          cur_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [7:0]    acc_q, alu_a_q, alu_b_q, res_data_q;
  logic [2:0]    alu_ctrl_q, alu_movl_q, alu_movr_q;
  logic [3:0]    res_flags_q;
  logic          res_valid_q;
  logic          full, empty, push, pop, issue_en, capture_en, resp_done;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  // A full FIFO refuses a push even when the FSM pops in the same cycle.
  assign push  = bus.cmd_valid && !full;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_shamt, bus.cmd_use_acc,
                                  bus.cmd_wb, bus.cmd_a, bus.cmd_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!empty) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP:    if (bus.res_ready) state_d = empty ? S_IDLE : S_ISSUE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop        = 1'b0;
    issue_en   = 1'b0;
    capture_en = 1'b0;
    resp_done  = 1'b0;
    case (state_q)
      S_IDLE:    pop = !empty;
      S_ISSUE:   issue_en = 1'b1;
      S_CAPTURE: capture_en = 1'b1;
      S_RESP: begin
        resp_done = bus.res_ready;
        pop       = bus.res_ready && !empty;
      end
      default: ;
    endcase
  end

  // Operand A reads acc during ISSUE, after any earlier write-back has landed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q       <= '0;
      acc_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      alu_movl_q  <= '0;
      alu_movr_q  <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_valid_q <= 1'b0;
    end else begin
      if (pop) cur_q <= mem_q[rd_ptr_q];
      if (issue_en) begin
        alu_a_q    <= cur_q.use_acc ? acc_q : cur_q.a;
        alu_b_q    <= cur_q.b;
        alu_ctrl_q <= cur_q.op;
        alu_movr_q <= (cur_q.op[2:1] == 2'b10) ? cur_q.shamt : 3'd0;
        alu_movl_q <= (cur_q.op[2:1] == 2'b11) ? cur_q.shamt : 3'd0;
      end
      if (capture_en) begin
        res_data_q  <= bus.alu_result;
        res_flags_q <= bus.alu_flags;
        res_valid_q <= 1'b1;
        if (cur_q.wb) acc_q <= bus.alu_result;
      end
      if (resp_done) res_valid_q <= 1'b0;
    end
  end

  assign bus.cmd_ready  = !full;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_ctrl   = alu_ctrl_q;
  assign bus.alu_movl   = alu_movl_q;
  assign bus.alu_movr   = alu_movr_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_flags  = res_flags_q;
  assign bus.acc        = acc_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.fifo_count = count_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU on the pins, table of single-command vectors,
// hand sequences for reset/backpressure/full/wrap, and a randomized run against a queue model.
module tb_alu_op_sequencer;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dut_state;

  alu_op_sequencer_if #(.AW(AW)) bus ();

  alu_op_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dut_state)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_resp = 0;

  logic [11:0] exp_q[$];
  logic [7:0]  m_acc;

  always @(posedge clk) cyc++;

  // Combinational ALU: {flags(z,n,c,v), result} from the pins.
  function automatic logic [11:0] alu_pins(input logic [2:0] ctrl, input logic [7:0] a,
                                           input logic [7:0] b, input logic [2:0] movl,
                                           input logic [2:0] movr);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, v;
    s = ctrl[0] ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    c = s[8];
    v = ctrl[0] ? ((a[7] != b[7]) && (s[7] != a[7])) : ((a[7] == b[7]) && (s[7] != a[7]));
    case (ctrl)
      3'd2: begin r = a & b; c = 1'b0; v = 1'b0; end
      3'd3: begin r = a | b; c = 1'b0; v = 1'b0; end
      3'd4, 3'd5: r = s[7:0] >> movr;
      3'd6, 3'd7: r = s[7:0] << movl;
      default: r = s[7:0];
    endcase
    return {(r == 8'h00), r[7], c, v, r};
  endfunction

  function automatic logic [11:0] model_res(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic [2:0] sh);
    logic [2:0] l, r;
    l = (op >= 3'd6) ? sh : 3'd0;
    r = (op == 3'd4 || op == 3'd5) ? sh : 3'd0;
    return alu_pins(op, a, b, l, r);
  endfunction

  assign {bus.alu_flags, bus.alu_result} =
    alu_pins(bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.alu_movl, bus.alu_movr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: every accepted command yields one response, in order; acc follows wb commands.
  always @(negedge clk) begin : scoreboard
    logic [7:0]  a;
    logic [11:0] e;
    if (rst) begin
      exp_q.delete();
      m_acc = 8'h00;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        a = bus.cmd_use_acc ? m_acc : bus.cmd_a;
        e = model_res(bus.cmd_op, a, bus.cmd_b, bus.cmd_shamt);
        if (bus.cmd_wb) m_acc = e[7:0];
        exp_q.push_back(e);
      end
      if (bus.res_valid && bus.res_ready) begin
        n_resp++;
        if (exp_q.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("sb_data", {24'd0, bus.res_data}, {24'd0, e[7:0]});
          check("sb_flags", {28'd0, bus.res_flags}, {28'd0, e[11:8]});
        end
      end
    end
  end

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] sh;
    logic       use_acc;
    logic       wb;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_alu_a;
    logic [7:0] exp_data;
    logic [7:0] exp_acc;
    logic [2:0] exp_movl;
    logic [2:0] exp_movr;
  } vec_t;

  vec_t tbl [10];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cmd(input logic [2:0] op, input logic [2:0] sh, input logic ua,
                         input logic wb, input logic [7:0] a, input logic [7:0] b);
    bus.cmd_op = op; bus.cmd_shamt = sh; bus.cmd_use_acc = ua;
    bus.cmd_wb = wb; bus.cmd_a = a; bus.cmd_b = b;
  endtask

  task automatic push(input logic [2:0] op, input logic [2:0] sh, input logic ua,
                      input logic wb, input logic [7:0] a, input logic [7:0] b);
    set_cmd(op, sh, ua, wb, a, b);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic push_random();
    set_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  task automatic wait_res_valid(input string name);
    int k = 0;
    while (!bus.res_valid && k < 20) begin tick(); k++; end
    check(name, {31'd0, bus.res_valid}, 32'd1);
  endtask

  task automatic drain(input string name);
    int k = 0;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    while ((bus.busy || exp_q.size() != 0) && k < 400) begin tick(); k++; end
    check(name, exp_q.size(), 32'd0);
  endtask

  task automatic run_one(input vec_t v, input int idx);
    int          k;
    int          p;
    logic [11:0] e;
    e = model_res(v.op, v.exp_alu_a, v.b, v.sh);
    push(v.op, v.sh, v.use_acc, v.wb, v.a, v.b);
    k = 0;
    while (!bus.busy && k < 5) begin tick(); k++; end
    check($sformatf("v%0d_pop", idx), {31'd0, bus.busy}, 32'd1);
    p = cyc;
    k = 0;
    while (!bus.res_valid && k < 8) begin tick(); k++; end
    check($sformatf("v%0d_latency", idx), cyc - p, 32'd2);
    check($sformatf("v%0d_data", idx), {24'd0, bus.res_data}, {24'd0, v.exp_data});
    check($sformatf("v%0d_flags", idx), {28'd0, bus.res_flags}, {28'd0, e[11:8]});
    check($sformatf("v%0d_flags_pass", idx), {28'd0, bus.res_flags}, {28'd0, bus.alu_flags});
    check($sformatf("v%0d_acc", idx), {24'd0, bus.acc}, {24'd0, v.exp_acc});
    check($sformatf("v%0d_alu_a", idx), {24'd0, bus.alu_a}, {24'd0, v.exp_alu_a});
    check($sformatf("v%0d_alu_b", idx), {24'd0, bus.alu_b}, {24'd0, v.b});
    check($sformatf("v%0d_ctrl", idx), {29'd0, bus.alu_ctrl}, {29'd0, v.op});
    check($sformatf("v%0d_movl", idx), {29'd0, bus.alu_movl}, {29'd0, v.exp_movl});
    check($sformatf("v%0d_movr", idx), {29'd0, bus.alu_movr}, {29'd0, v.exp_movr});
    tick();
    check($sformatf("v%0d_res_clear", idx), {31'd0, bus.res_valid}, 32'd0);
    check($sformatf("v%0d_idle", idx), {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int         n0;
    int         k;
    logic [1:0] s0;
    logic       acc_ok;

    //                op    sh    ua    wb    a      b      alu_a  data   acc    movl  movr
    tbl[0] = '{3'd0, 3'd0, 1'b0, 1'b1, 8'h05, 8'h03, 8'h05, 8'h08, 8'h08, 3'd0, 3'd0};
    tbl[1] = '{3'd1, 3'd0, 1'b1, 1'b1, 8'h55, 8'h01, 8'h08, 8'h07, 8'h07, 3'd0, 3'd0};
    tbl[2] = '{3'd4, 3'd2, 1'b0, 1'b0, 8'h40, 8'h00, 8'h40, 8'h10, 8'h07, 3'd0, 3'd2};
    tbl[3] = '{3'd2, 3'd5, 1'b0, 1'b0, 8'hAA, 8'h0F, 8'hAA, 8'h0A, 8'h07, 3'd0, 3'd0};
    tbl[4] = '{3'd6, 3'd3, 1'b0, 1'b0, 8'h01, 8'h01, 8'h01, 8'h10, 8'h07, 3'd3, 3'd0};
    tbl[5] = '{3'd3, 3'd0, 1'b0, 1'b1, 8'hF0, 8'h0F, 8'hF0, 8'hFF, 8'hFF, 3'd0, 3'd0};
    tbl[6] = '{3'd5, 3'd4, 1'b1, 1'b1, 8'h00, 8'h0F, 8'hFF, 8'h0F, 8'h0F, 3'd0, 3'd4};
    tbl[7] = '{3'd7, 3'd1, 1'b0, 1'b0, 8'h10, 8'h11, 8'h10, 8'hFE, 8'h0F, 3'd1, 3'd0};
    tbl[8] = '{3'd0, 3'd6, 1'b1, 1'b1, 8'h00, 8'hF1, 8'h0F, 8'h00, 8'h00, 3'd0, 3'd0};
    tbl[9] = '{3'd1, 3'd0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h00, 3'd0, 3'd0};

    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b0;
    set_cmd(3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();

    check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_count", {29'd0, bus.fifo_count}, 32'd0);
    check("rst_acc", {24'd0, bus.acc}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_alu", {bus.alu_a, bus.alu_b, 2'b00, bus.alu_ctrl, bus.alu_movl, bus.alu_movr},
          32'd0);
    check("rst_res", {20'd0, bus.res_flags, bus.res_data}, 32'd0);
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    rst = 1'b0;
    tick();

    bus.res_ready = 1'b1;
    for (int i = 0; i < 10; i++) run_one(tbl[i], i);

    // Backpressure: result and issue must freeze while res_ready is low.
    bus.res_ready = 1'b0;
    push(3'd3, 3'd0, 1'b0, 1'b0, 8'hF0, 8'h0F);
    push(3'd0, 3'd0, 1'b0, 1'b0, 8'h01, 8'h01);
    wait_res_valid("bp_res_valid");
    s0 = dut_state;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid_hold", {31'd0, bus.res_valid}, 32'd1);
      check("bp_data_hold", {24'd0, bus.res_data}, 32'hFF);
      check("bp_no_issue", {29'd0, bus.fifo_count}, 32'd1);
      check("bp_ctrl_hold", {29'd0, bus.alu_ctrl}, 32'd3);
      check("bp_state_hold", {30'd0, dut_state}, {30'd0, s0});
    end
    drain("bp_drain");

    // Full FIFO: one command in flight plus DEPTH queued.
    bus.res_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      push_random();
      bus.cmd_valid = 1'b1;
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("full_count", {29'd0, bus.fifo_count}, DEPTH);
    check("full_ready", {31'd0, bus.cmd_ready}, 32'd0);
    push(3'd0, 3'd0, 1'b0, 1'b1, 8'h77, 8'h77);
    check("full_drop", {29'd0, bus.fifo_count}, DEPTH);
    wait_res_valid("full_res_valid");
    push_random();
    bus.cmd_valid = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("full_pop_no_push", {29'd0, bus.fifo_count}, DEPTH - 1);
    drain("full_drain");

    // Wrap: 2*DEPTH accepted commands with res_ready held high.
    n0 = n_resp;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      push_random();
      bus.cmd_valid = 1'b1;
      k = 0;
      acc_ok = 1'b0;
      while (!acc_ok && k < 20) begin
        acc_ok = bus.cmd_ready;
        tick();
        k++;
      end
      check("wrap_accept", {31'd0, acc_ok}, 32'd1);
    end
    bus.cmd_valid = 1'b0;
    drain("wrap_drain");
    check("wrap_resp_count", n_resp - n0, 2 * DEPTH);

    // Asynchronous reset mid-RESP with two commands queued.
    bus.res_ready = 1'b0;
    push(3'd0, 3'd0, 1'b0, 1'b1, 8'h12, 8'h34);
    push(3'd1, 3'd0, 1'b0, 1'b1, 8'h09, 8'h02);
    push(3'd2, 3'd0, 1'b0, 1'b1, 8'hFF, 8'h3C);
    wait_res_valid("t1_res_valid");
    check("t1_pre_count", {29'd0, bus.fifo_count}, 32'd2);
    check("t1_pre_acc", {24'd0, bus.acc}, 32'h46);
    rst = 1'b1;
    #1;
    check("t1_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("t1_count", {29'd0, bus.fifo_count}, 32'd0);
    check("t1_acc", {24'd0, bus.acc}, 32'd0);
    check("t1_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    rst = 1'b0;
    n0 = n_resp;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("t1_no_resp", n_resp - n0, 32'd0);
    check("t1_still_idle", {31'd0, bus.busy}, 32'd0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      push_random();
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
